// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the alu_seq block.
package alu_seq_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_ADD  = 4'd7;
    localparam logic [3:0] OP_MULT = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    // flags output is packed as {Z,N,C,V}
    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/alu_seq_mult.sv
// Iterative shift-add unsigned multiplier: N steps after start, done_o marks the final step
// and lo_o/hi_o carry the completed product during that cycle. abort_i drops a run silently.
module seq_mult #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         done_o,
    output logic [N-1:0] lo_o,
    output logic [N-1:0] hi_o
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [2*N-1:0] mcand_q;
    logic [2*N-1:0] prod_q;
    logic [2*N-1:0] prod_d;
    logic [N-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;
    logic           run_q;

    assign prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o = run_q && (cnt_q == CW'(N - 1));
    assign lo_o   = prod_d[N-1:0];
    assign hi_o   = prod_d[2*N-1:N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (abort_i) begin
            run_q <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{N{1'b0}}, a_i};
            mplier_q <= b_i;
            prod_q   <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-accumulator sequential ALU with power control and a multi-cycle multiplier.
// Define ALU_SEQ_SHIFT_EN to add SHL (opcode 9) and SHR (opcode 10).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int NACC = 4,
    localparam int SELW = (NACC > 1) ? $clog2(NACC) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            on,
    input  logic            off,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [3:0]      op,
    input  logic [SELW-1:0] acc_sel,
    input  logic [N-1:0]    in_data,
    input  logic [SELW-1:0] rd_sel,
    output logic [N-1:0]    out,
    output logic [3:0]      flags,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic            pwr
);

    state_t          state_q;
    logic [N-1:0]    acc_q [NACC];
    logic [N-1:0]    acc_d [NACC];
    logic [3:0]      flags_q;
    logic [3:0]      flags_d;
    logic [N-1:0]    out_q;
    logic            done_q;
    logic            illegal_q;
    logic [SELW-1:0] mul_sel_q;

    logic            go_off;
    logic            accept;
    logic            out_off_d;
    logic [N-1:0]    opa;
    logic [N:0]      sum_w;
    logic [N:0]      diff_w;
    logic [N-1:0]    alu_res;
    logic            alu_c;
    logic            alu_v;
    logic            alu_wr;
    logic            alu_fwr;
    logic            alu_illegal;
    logic [3:0]      alu_flags;
    logic [3:0]      mul_flags;
    logic            mul_start;
    logic            mul_done;
    logic [N-1:0]    mul_lo;
    logic [N-1:0]    mul_hi;

    // on beats off; an op is only taken in a cycle with no power request
    assign go_off    = !on && off;
    assign accept    = op_valid && (state_q == ST_IDLE) && !on && !off;
    assign out_off_d = !on && (off || (state_q == ST_OFF));
    assign mul_start = accept && (op == OP_MULT);
    assign opa       = acc_q[acc_sel];

`ifdef ALU_SEQ_SHIFT_EN
    logic [N-1:0] sh_amt;
    assign sh_amt = in_data % N'(N);
`endif

    always_comb begin
        sum_w       = {1'b0, opa} + {1'b0, in_data};
        diff_w      = {1'b0, opa} - {1'b0, in_data};
        alu_res     = opa;
        alu_c       = 1'b0;
        alu_v       = 1'b0;
        alu_wr      = 1'b0;
        alu_fwr     = 1'b0;
        alu_illegal = 1'b0;
        case (op)
            OP_NOP:  ;
            OP_LOAD: begin alu_res = in_data;       alu_wr = 1'b1; alu_fwr = 1'b1; end
            OP_NOT:  begin alu_res = ~opa;          alu_wr = 1'b1; alu_fwr = 1'b1; end
            OP_XOR:  begin alu_res = opa ^ in_data; alu_wr = 1'b1; alu_fwr = 1'b1; end
            OP_OR:   begin alu_res = opa | in_data; alu_wr = 1'b1; alu_fwr = 1'b1; end
            OP_AND:  begin alu_res = opa & in_data; alu_wr = 1'b1; alu_fwr = 1'b1; end
            OP_SUB: begin
                alu_res = diff_w[N-1:0];
                alu_c   = diff_w[N];
                alu_v   = (opa[N-1] != in_data[N-1]) && (diff_w[N-1] != opa[N-1]);
                alu_wr  = 1'b1;
                alu_fwr = 1'b1;
            end
            OP_ADD: begin
                alu_res = sum_w[N-1:0];
                alu_c   = sum_w[N];
                alu_v   = (opa[N-1] == in_data[N-1]) && (sum_w[N-1] != opa[N-1]);
                alu_wr  = 1'b1;
                alu_fwr = 1'b1;
            end
            OP_MULT: ;
`ifdef ALU_SEQ_SHIFT_EN
            // the extra bit on each side catches the last bit shifted out
            OP_SHL: begin {alu_c, alu_res} = {1'b0, opa} << sh_amt; alu_wr = 1'b1; alu_fwr = 1'b1; end
            OP_SHR: begin {alu_res, alu_c} = {opa, 1'b0} >> sh_amt; alu_wr = 1'b1; alu_fwr = 1'b1; end
`endif
            default: alu_illegal = 1'b1;
        endcase
        alu_flags        = '0;
        alu_flags[FLG_Z] = (alu_res == '0);
        alu_flags[FLG_N] = alu_res[N-1];
        alu_flags[FLG_C] = alu_c;
        alu_flags[FLG_V] = alu_v;
    end

    always_comb begin
        mul_flags        = '0;
        mul_flags[FLG_Z] = (mul_lo == '0);
        mul_flags[FLG_N] = mul_lo[N-1];
        mul_flags[FLG_C] = |mul_hi;
        mul_flags[FLG_V] = |mul_hi;
    end

    seq_mult #(.N(N)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mul_start),
        .abort_i (go_off),
        .a_i     (opa),
        .b_i     (in_data),
        .done_o  (mul_done),
        .lo_o    (mul_lo),
        .hi_o    (mul_hi)
    );

    always_comb begin
        acc_d   = acc_q;
        flags_d = flags_q;
        if (go_off) begin
            for (int i = 0; i < NACC; i++) begin
                acc_d[i] = '0;
            end
            flags_d = '0;
        end else if (accept) begin
            if (alu_wr) begin
                acc_d[acc_sel] = alu_res;
            end
            if (alu_fwr) begin
                flags_d = alu_flags;
            end
        end else if ((state_q == ST_MUL) && mul_done) begin
            acc_d[mul_sel_q] = mul_lo;
            flags_d          = mul_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NACC; i++) begin
                acc_q[i] <= '0;
            end
            flags_q <= '0;
            out_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
            out_q   <= out_off_d ? '0 : acc_d[rd_sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            mul_sel_q <= '0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                ST_OFF: begin
                    if (on) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (go_off) begin
                        state_q <= ST_OFF;
                    end else if (accept) begin
                        if (op == OP_MULT) begin
                            state_q   <= ST_MUL;
                            mul_sel_q <= acc_sel;
                        end else begin
                            done_q    <= 1'b1;
                            illegal_q <= alu_illegal;
                        end
                    end
                end
                ST_MUL: begin
                    if (go_off) begin
                        state_q <= ST_OFF;
                    end else if (mul_done) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign op_ready = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_MUL);
    assign pwr      = (state_q != ST_OFF);
    assign out      = out_q;
    assign flags    = flags_q;
    assign done     = done_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=8, NACC=4): an arithmetic reference model predicts every
// output each cycle, plus literal checks on the key vectors.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       on       = 1'b0;
    logic       off      = 1'b0;
    logic       op_valid = 1'b0;
    logic [3:0] op       = 4'd0;
    logic [1:0] acc_sel  = 2'd0;
    logic [1:0] rd_sel   = 2'd0;
    logic [7:0] in_data  = 8'd0;
    logic       op_ready;
    logic [7:0] out;
    logic [3:0] flags;
    logic       busy;
    logic       done;
    logic       illegal;
    logic       pwr;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         m_acc [4];
    logic [3:0] m_flags;
    logic [7:0] m_out;
    bit         m_pwr;
    bit         m_done;
    bit         m_ill;
    int         m_mul_left;
    int         m_mul_res;
    int         m_mul_sel;

    alu_seq #(.N(8), .NACC(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .on       (on),
        .off      (off),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .acc_sel  (acc_sel),
        .in_data  (in_data),
        .rd_sel   (rd_sel),
        .out      (out),
        .flags    (flags),
        .busy     (busy),
        .done     (done),
        .illegal  (illegal),
        .pwr      (pwr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int sx(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    function automatic logic [3:0] mkf(input int r, input bit c, input bit v);
        return {r == 0, r > 127, c, v};
    endfunction

    task automatic model_reset();
        m_acc      = '{default: 0};
        m_flags    = 4'd0;
        m_out      = 8'd0;
        m_pwr      = 1'b1;
        m_done     = 1'b0;
        m_ill      = 1'b0;
        m_mul_left = 0;
        m_mul_res  = 0;
        m_mul_sel  = 0;
    endtask

    // one clock edge of the block's rules, in plain integer arithmetic
    task automatic model_update();
        int a, b, r, s, amt;
        bit c, v, wr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        m_ill  = 1'b0;
        if (!on && off) begin
            m_pwr      = 1'b0;
            m_acc      = '{default: 0};
            m_flags    = 4'd0;
            m_mul_left = 0;
        end else begin
            if (on) m_pwr = 1'b1;
            if (m_mul_left > 0) begin
                m_mul_left--;
                if (m_mul_left == 0) begin
                    m_acc[m_mul_sel] = m_mul_res & 255;
                    m_flags = mkf(m_mul_res & 255, m_mul_res > 255, m_mul_res > 255);
                    m_done  = 1'b1;
                end
            end else if (!on && m_pwr && op_valid) begin
                a = m_acc[acc_sel];
                b = in_data;
                r = 0; c = 0; v = 0; wr = 1; amt = 0;
                m_done = 1'b1;
                case (op)
                    4'd0: wr = 0;
                    4'd1: r = b;
                    4'd2: r = (~a) & 255;
                    4'd3: r = a ^ b;
                    4'd4: r = a | b;
                    4'd5: r = a & b;
                    4'd6: begin r = (a - b) & 255; c = a < b; s = sx(a) - sx(b); v = (s < -128) || (s > 127); end
                    4'd7: begin r = (a + b) & 255; c = (a + b) > 255; s = sx(a) + sx(b); v = (s < -128) || (s > 127); end
                    4'd8: begin wr = 0; m_done = 1'b0; m_mul_left = 8; m_mul_res = a * b; m_mul_sel = acc_sel; end
`ifdef ALU_SEQ_SHIFT_EN
                    4'd9: begin amt = b % 8; r = (a << amt) & 255; c = (amt != 0) && (((a >> (8 - amt)) & 1) != 0); end
                    4'd10: begin amt = b % 8; r = a >> amt; c = (amt != 0) && (((a >> (amt - 1)) & 1) != 0); end
`endif
                    default: begin wr = 0; m_ill = 1'b1; end
                endcase
                if (wr) begin
                    m_acc[acc_sel] = r;
                    m_flags = mkf(r, c, v);
                end
            end
        end
        m_out = m_pwr ? 8'(m_acc[rd_sel]) : 8'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        #2 rst_n = 1'b1;
    endtask

    task automatic do_op(input logic [3:0] o, input logic [1:0] s, input logic [7:0] d);
        op       = o;
        acc_sel  = s;
        in_data  = d;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        $display("op=%0d acc=%0d data=%02h -> out=%02h flags=%b done=%0b illegal=%0b busy=%0b pwr=%0b",
                 o, s, d, out, flags, done, illegal, busy, pwr);
    endtask

    task automatic expect_out(input string name, input logic [7:0] v);
        check({name, "_out"}, out, v);
        check({name, "_model_out"}, m_out, v);
    endtask

    task automatic expect_flags(input string name, input logic [3:0] v);
        check({name, "_flags"}, flags, v);
        check({name, "_model_flags"}, m_flags, v);
    endtask

    task automatic sweep_zero(input string name, input int first);
        for (int i = first; i < 4; i++) begin
            rd_sel = 2'(i);
            tick();
            check($sformatf("%s_acc%0d", name, i), out, 8'h00);
        end
    endtask

    // every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            check("cycle", {out, flags, pwr, op_ready, busy, done, illegal},
                  {m_out, m_flags, m_pwr, (m_pwr && m_mul_left == 0), (m_mul_left > 0), m_done, m_ill});
        end
    end

    initial begin
        model_reset();
        apply_reset();
        expect_out("rst", 8'h00);
        check("rst_pwr", pwr, 1);
        check("rst_ready", op_ready, 1);
        check("rst_flags", flags, 0);

        // reset in cycle 3 of a multiplication
        rd_sel = 2'd1;
        do_op(OP_LOAD, 2'd1, 8'h05);
        expect_out("load1", 8'h05);
        do_op(OP_MULT, 2'd1, 8'h03);
        idle(2);
        check("mul_busy_pre_rst", busy, 1);
        apply_reset();
        check("rmul_busy", busy, 0);
        check("rmul_ready", op_ready, 1);
        check("rmul_pwr", pwr, 1);
        check("rmul_flags", flags, 0);
        idle(10);
        sweep_zero("rmul", 0);

        // load then add
        rd_sel = 2'd0;
        do_op(OP_LOAD, 2'd0, 8'h10);
        do_op(OP_ADD, 2'd0, 8'h02);
        expect_out("add", 8'h12);
        expect_flags("add", 4'b0000);
        check("add_done", done, 1);
        sweep_zero("add", 1);

        // arithmetic boundaries on acc2
        rd_sel = 2'd2;
        do_op(OP_LOAD, 2'd2, 8'hFF);
        do_op(OP_ADD, 2'd2, 8'h01);
        expect_out("add_wrap", 8'h00);
        expect_flags("add_wrap", 4'b1010);
        do_op(OP_SUB, 2'd2, 8'h01);
        expect_out("sub_borrow", 8'hFF);
        expect_flags("sub_borrow", 4'b0110);
        do_op(OP_LOAD, 2'd2, 8'h7F);
        do_op(OP_ADD, 2'd2, 8'h01);
        expect_out("add_ovf", 8'h80);
        expect_flags("add_ovf", 4'b0101);
        do_op(OP_LOAD, 2'd2, 8'h80);
        do_op(OP_SUB, 2'd2, 8'h01);
        expect_out("sub_ovf", 8'h7F);
        expect_flags("sub_ovf", 4'b0001);

        // logic ops on acc3
        rd_sel = 2'd3;
        do_op(OP_LOAD, 2'd3, 8'hA5);
        do_op(OP_NOT, 2'd3, 8'h00);
        expect_out("not", 8'h5A);
        do_op(OP_XOR, 2'd3, 8'hFF);
        expect_out("xor", 8'hA5);
        expect_flags("xor", 4'b0100);
        do_op(OP_OR, 2'd3, 8'h0F);
        expect_out("or", 8'hAF);
        do_op(OP_AND, 2'd3, 8'h0F);
        expect_out("and", 8'h0F);
        do_op(OP_AND, 2'd3, 8'h00);
        expect_flags("and_zero", 4'b1000);
        do_op(OP_NOP, 2'd3, 8'h55);
        expect_out("nop", 8'h00);
        expect_flags("nop", 4'b1000);
        check("nop_done", done, 1);

        // multiply with a competing request held valid throughout
        rd_sel = 2'd0;
        do_op(OP_LOAD, 2'd0, 8'h06);
        op = OP_MULT; acc_sel = 2'd0; in_data = 8'h04; op_valid = 1'b1;
        tick();
        op = OP_ADD; in_data = 8'h01;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("mul_busy_%0d", i), busy, (i < 8) ? 1 : 0);
        end
        op_valid = 1'b0;
        expect_out("mul", 8'h18);
        expect_flags("mul", 4'b0000);
        check("mul_done", done, 1);
        idle(1);
        expect_out("mul_hold", 8'h18);

        do_op(OP_LOAD, 2'd0, 8'h20);
        do_op(OP_MULT, 2'd0, 8'h10);
        idle(8);
        expect_out("mul_hi", 8'h00);
        expect_flags("mul_hi", 4'b1011);

        // on (alone and together with off) while multiplying does not disturb it
        rd_sel = 2'd1;
        do_op(OP_LOAD, 2'd1, 8'h07);
        do_op(OP_MULT, 2'd1, 8'h09);
        on = 1'b1;
        idle(2);
        off = 1'b1;
        idle(1);
        on = 1'b0; off = 1'b0;
        idle(5);
        expect_out("mul_on", 8'h3F);
        check("mul_on_done", done, 1);

        // off during multiplication
        do_op(OP_LOAD, 2'd1, 8'h33);
        rd_sel = 2'd0;
        do_op(OP_LOAD, 2'd0, 8'h03);
        do_op(OP_MULT, 2'd0, 8'h05);
        idle(3);
        off = 1'b1;
        tick();
        off = 1'b0;
        check("off_pwr", pwr, 0);
        check("off_ready", op_ready, 0);
        check("off_busy", busy, 0);
        expect_out("off", 8'h00);
        idle(10);
        do_op(OP_LOAD, 2'd0, 8'hAA);
        expect_out("off_ignored", 8'h00);
        on = 1'b1;
        tick();
        on = 1'b0;
        check("on_pwr", pwr, 1);
        expect_flags("on", 4'b0000);
        sweep_zero("on", 0);

        off = 1'b1;
        tick();
        off = 1'b0;
        check("off2_pwr", pwr, 0);
        on = 1'b1; off = 1'b1;
        tick();
        on = 1'b0; off = 1'b0;
        check("onoff_pwr", pwr, 1);
        check("onoff_ready", op_ready, 1);

        // undefined opcode leaves state untouched
        rd_sel = 2'd0;
        do_op(OP_LOAD, 2'd0, 8'h44);
        do_op(OP_ADD, 2'd0, 8'hC0);
        expect_flags("pre_ill", 4'b0010);
        do_op(4'hC, 2'd0, 8'h99);
        check("ill_pulse", illegal, 1);
        check("ill_done", done, 1);
        expect_out("ill", 8'h04);
        expect_flags("ill", 4'b0010);
        idle(1);
        check("ill_clear", illegal, 0);

`ifdef ALU_SEQ_SHIFT_EN
        do_op(OP_LOAD, 2'd0, 8'h81);
        do_op(OP_SHL, 2'd0, 8'h01);
        expect_out("shl", 8'h02);
        expect_flags("shl", 4'b0010);
        do_op(OP_LOAD, 2'd0, 8'h81);
        do_op(OP_SHR, 2'd0, 8'h0B);
        expect_out("shr", 8'h10);
        expect_flags("shr", 4'b0000);
        do_op(OP_SHL, 2'd0, 8'h08);
        expect_out("shl0", 8'h10);
        expect_flags("shl0", 4'b0000);
`else
        do_op(OP_SHL, 2'd0, 8'h01);
        check("op9_ill", illegal, 1);
        expect_out("op9", 8'h04);
        expect_flags("op9", 4'b0010);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
